// File: rtl/rsa256_avalon_wrapper_if.sv
// Avalon-MM bundle between the RSA-256 byte-stream front end
// and the RS-232 UART slave.
interface rsa256_avalon_wrapper_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/rsa256_avalon_wrapper.sv
// RSA-256 front end: polls the UART over Avalon-MM, assembles N, d and
// ciphertexts, starts the core and streams the low 31 result bytes back.
module rsa256_avalon_wrapper #(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    rsa256_avalon_wrapper_if.master avm,
    output logic                    o_core_start,
    output logic [255:0]            o_core_a,
    output logic [255:0]            o_core_d,
    output logic [255:0]            o_core_n,
    input  logic [255:0]            i_core_result,
    input  logic                    i_core_finished
);

    typedef enum logic [1:0] {
        S_GET_KEY,
        S_GET_DATA,
        S_WAIT_CALC,
        S_SEND_DATA
    } state_t;

    state_t         state_q;
    logic           data_ph_q;
    logic           rd_q;
    logic           wr_q;
    logic [4:0]     addr_q;
    logic [7:0]     wdata_q;
    logic           start_q;
    logic [255:0]   n_q;
    logic [255:0]   d_q;
    logic [255:0]   a_q;
    logic [247:0]   out_q;
    logic [6:0]     cnt_q;

    logic           xfer_done;
    logic           rx_mode;
    logic           tx_mode;
    logic           stat_ok;
    logic [7:0]     rx_byte;
    logic [6:0]     cnt_d;
    logic           unused_bits;

    assign xfer_done = (rd_q | wr_q) & ~avm.avm_waitrequest;
    assign rx_mode   = (state_q == S_GET_KEY) || (state_q == S_GET_DATA);
    assign tx_mode   = (state_q == S_SEND_DATA);
    assign rx_byte   = avm.avm_readdata[7:0];
    assign stat_ok   = rx_mode ? avm.avm_readdata[7] : avm.avm_readdata[6];
    assign cnt_d     = cnt_q + 7'd1;

    // The top result byte is never transmitted and only the low UART byte carries data.
    assign unused_bits = ^{i_core_result[255:248], avm.avm_readdata[31:8]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_GET_KEY;
            data_ph_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= STATUS_BASE;
            wdata_q   <= 8'h00;
            start_q   <= 1'b0;
            n_q       <= '0;
            d_q       <= '0;
            a_q       <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
        end else begin
            start_q <= 1'b0;
            if (rd_q || wr_q) begin
                if (xfer_done) begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (!data_ph_q) begin
                        data_ph_q <= stat_ok;
                    end else begin
                        data_ph_q <= 1'b0;
                        cnt_q     <= cnt_d;
                        unique case (state_q)
                            S_GET_KEY: begin
                                if (!cnt_q[5]) n_q <= {n_q[247:0], rx_byte};
                                else           d_q <= {d_q[247:0], rx_byte};
                                if (cnt_q == 7'd63) begin
                                    state_q <= S_GET_DATA;
                                    cnt_q   <= '0;
                                end
                            end
                            S_GET_DATA: begin
                                a_q <= {a_q[247:0], rx_byte};
                                if (cnt_q == 7'd31) begin
                                    state_q <= S_WAIT_CALC;
                                    cnt_q   <= '0;
                                    start_q <= 1'b1;
                                end
                            end
                            S_SEND_DATA: begin
                                out_q <= {out_q[239:0], 8'h00};
                                if (cnt_q == 7'd30) begin
                                    state_q <= S_GET_DATA;
                                    cnt_q   <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (rx_mode || tx_mode) begin
                // Idle gap cycle: issue the next status poll or data transfer.
                if (!data_ph_q) begin
                    rd_q   <= 1'b1;
                    addr_q <= STATUS_BASE;
                end else if (rx_mode) begin
                    rd_q   <= 1'b1;
                    addr_q <= RX_BASE;
                end else begin
                    wr_q    <= 1'b1;
                    addr_q  <= TX_BASE;
                    wdata_q <= out_q[247:240];
                end
            end else if (i_core_finished && !start_q) begin
                out_q   <= i_core_result[247:0];
                state_q <= S_SEND_DATA;
            end
        end
    end

    assign avm.avm_address   = addr_q;
    assign avm.avm_read      = rd_q;
    assign avm.avm_write     = wr_q;
    assign avm.avm_writedata = {24'h000000, wdata_q};
    assign o_core_start      = start_q;
    assign o_core_a          = a_q;
    assign o_core_d          = d_q;
    assign o_core_n          = n_q;

endmodule
